// File: rtl/sram_controller_pkg.sv
// sram_controller_pkg: shared state encoding and defaults for the cache-to-SRAM bridge.
package sram_controller_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LO_ACC = 2'd1,
        HI_ACC = 2'd2,
        DONE   = 2'd3
    } state_t;
    localparam int WAIT_CYCLES_DEF = 2;
    localparam int SRAM_ADDR_W = 18;
    localparam int HALF_W = 16;
endpackage

// File: rtl/sram_controller_if.sv
// sram_controller_if: cache-side request/response bundle of the SRAM controller.
interface sram_controller_if;
    logic        write_en;
    logic        read_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        busy;
    modport master (output write_en, read_en, address, write_data, input read_data, ready, busy);
    modport slave (input write_en, read_en, address, write_data, output read_data, ready, busy);
endinterface

// File: rtl/sram_controller.sv
// sram_controller: splits 32-bit cache requests into two 16-bit async SRAM accesses.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    sram_controller_if.slave  bus,
    inout  wire  [HALF_W-1:0] SRAM_DQ,
    output logic [ADDR_W-1:0] SRAM_ADDR_O,
    output logic              SRAM_WE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_CE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N
);
    localparam int CW = $clog2(WAIT_CYCLES + 1);
    state_t            state;
    logic [CW-1:0]     cnt;
    logic              op_wr;
    logic [ADDR_W-2:0] page;
    logic [HALF_W-1:0] wd_hi;
    logic [HALF_W-1:0] lo_q;
    logic [31:0]       rd_q;
    logic              ready_q;
    logic              busy_q;
    logic [HALF_W-1:0] dq_out;
    logic              dq_oe;
    logic              last;
    assign last = cnt == CW'(WAIT_CYCLES - 1);
    assign SRAM_DQ = dq_oe ? dq_out : 'z;
    assign SRAM_UB_N = SRAM_CE_N;
    assign SRAM_LB_N = SRAM_CE_N;
    assign bus.read_data = rd_q;
    assign bus.ready = ready_q;
    assign bus.busy = busy_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            op_wr       <= 1'b0;
            page        <= '0;
            wd_hi       <= '0;
            lo_q        <= '0;
            rd_q        <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            SRAM_ADDR_O <= '0;
            SRAM_WE_N   <= 1'b1;
            SRAM_OE_N   <= 1'b1;
            SRAM_CE_N   <= 1'b1;
            dq_oe       <= 1'b0;
            dq_out      <= '0;
        end else begin
            ready_q <= 1'b0;
            case (state)
                IDLE: if (bus.write_en || bus.read_en) begin
                    state       <= LO_ACC;
                    cnt         <= '0;
                    op_wr       <= bus.write_en;
                    page        <= bus.address[ADDR_W:2];
                    wd_hi       <= bus.write_data[31:16];
                    busy_q      <= 1'b1;
                    SRAM_ADDR_O <= {bus.address[ADDR_W:2], 1'b0};
                    SRAM_CE_N   <= 1'b0;
                    SRAM_OE_N   <= bus.write_en;
                    SRAM_WE_N   <= ~bus.write_en;
                    dq_oe       <= bus.write_en;
                    dq_out      <= bus.write_data[15:0];
                end
                LO_ACC, HI_ACC: begin
                    cnt <= last ? '0 : cnt + 1'b1;
                    // WE_N rises one cycle before the address moves so data holds past the strobe
                    if (!last)
                        SRAM_WE_N <= ~op_wr | (cnt + 1'b1 == CW'(WAIT_CYCLES - 1));
                    else if (state == LO_ACC) begin
                        state       <= HI_ACC;
                        SRAM_ADDR_O <= {page, 1'b1};
                        SRAM_WE_N   <= ~op_wr;
                        dq_out      <= wd_hi;
                        if (!op_wr) lo_q <= SRAM_DQ;
                    end else begin
                        state     <= DONE;
                        ready_q   <= 1'b1;
                        SRAM_CE_N <= 1'b1;
                        SRAM_OE_N <= 1'b1;
                        SRAM_WE_N <= 1'b1;
                        dq_oe     <= 1'b0;
                        if (!op_wr) rd_q <= {SRAM_DQ, lo_q};
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed stimulus with a ready-driven scoreboard and an async SRAM model.
module tb_sram_controller;
    import sram_controller_pkg::*;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        we_n, oe_n, ce_n, ub_n, lb_n;
    logic [15:0] mem [0:1023];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;
    exp_t q[$];

    sram_controller_if bus();

    sram_controller dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .SRAM_DQ(sram_dq),
        .SRAM_ADDR_O(sram_addr),
        .SRAM_WE_N(we_n),
        .SRAM_OE_N(oe_n),
        .SRAM_CE_N(ce_n),
        .SRAM_UB_N(ub_n),
        .SRAM_LB_N(lb_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign sram_dq = (ce_n === 1'b0 && oe_n === 1'b0) ? mem[sram_addr[9:0]] : 16'hzzzz;
    always @(posedge we_n) if (ce_n === 1'b0) mem[sram_addr[9:0]] <= sram_dq;

    always @(negedge clk) begin
        if (bus.ready === 1'b1) begin
            exp_t e;
            n_cmp++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ready: read_data=%h at cycle %0d, no request outstanding", bus.read_data, cyc);
            end else begin
                e = q.pop_front();
                if (bus.read_data !== e.d || cyc != e.c) begin
                    n_fail++;
                    $display("FAIL ready_response: got data %h at cycle %0d, want %h at cycle %0d", bus.read_data, cyc, e.d, e.c);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 30 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ready_timeout: got %0d pending want 0", q.size());
            q.delete();
        end
    endtask

    task automatic check_idle(input string nm);
        chk({nm, "_ctl"}, {28'd0, bus.ready, bus.busy, we_n, oe_n}, {28'd0, 2'b00, 2'b11});
        chk({nm, "_ce"}, {29'd0, ce_n, ub_n, lb_n}, 32'd7);
        chk({nm, "_rdata"}, bus.read_data, 32'd0);
        chk({nm, "_dq"}, {16'd0, sram_dq}, 32'h0000_zzzz);
    endtask

    task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] ed, input logic [17:0] ea);
        @(negedge clk);
        bus.write_en = wr;
        bus.read_en = rd;
        bus.address = a;
        bus.write_data = wd;
        q.push_back('{ed, cyc + 5});
        for (int h = 0; h < 2; h++) begin
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                bus.write_en = 1'b0;
                bus.read_en = 1'b0;
                chk($sformatf("pins_h%0d_c%0d", h, k), {10'd0, sram_addr, we_n, oe_n, ce_n, bus.busy},
                    {10'd0, ea + 18'(h), wr ? (k == 1) : 1'b1, wr, 1'b0, 1'b1});
                if (wr) chk($sformatf("wdq_h%0d_c%0d", h, k), {16'd0, sram_dq}, {16'd0, h ? wd[31:16] : wd[15:0]});
            end
        end
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d want completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n, seen;
        bus.write_en = 1'b0;
        bus.read_en = 1'b0;
        bus.address = '0;
        bus.write_data = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[10'h100] = 16'hBEEF;
        mem[10'h101] = 16'hDEAD;
        #12 reset = 1'b0;
        #1 check_idle("reset");
        chk("reset_addr", {14'd0, sram_addr}, 32'd0);
        @(negedge clk) reset = 1'b1;

        access(1'b0, 1'b1, 32'h0000_0200, 32'h0, 32'hDEADBEEF, 18'h00100);
        access(1'b1, 1'b0, 32'h0000_0404, 32'h12345678, 32'hDEADBEEF, 18'h00202);
        chk("mem_lo", {16'd0, mem[10'h202]}, 32'h5678);
        chk("mem_hi", {16'd0, mem[10'h203]}, 32'h1234);
        access(1'b0, 1'b1, 32'h0000_0404, 32'h0, 32'h12345678, 18'h00202);
        access(1'b1, 1'b1, 32'h0000_0408, 32'hCAFEF00D, 32'h12345678, 18'h00204);
        access(1'b0, 1'b1, 32'hABC0_040B, 32'h0, 32'hCAFEF00D, 18'h00204);

        @(negedge clk);
        bus.read_en = 1'b1;
        bus.address = 32'h0000_0200;
        @(negedge clk) bus.read_en = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1 check_idle("abort");
        repeat (8) @(negedge clk);
        reset = 1'b1;
        access(1'b0, 1'b1, 32'h0000_0200, 32'h0, 32'hDEADBEEF, 18'h00100);

        @(negedge clk);
        bus.read_en = 1'b1;
        bus.address = 32'h0000_0404;
        n = cyc;
        q.push_back('{32'h12345678, n + 5});
        q.push_back('{32'h12345678, n + 11});
        seen = 0;
        for (int i = 0; i < 30 && seen < 2; i++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) seen++;
        end
        bus.read_en = 1'b0;
        wait_done();
        repeat (2) @(negedge clk);
        chk("held_no_third", {31'd0, bus.busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Downstream stage of the data cache. Converts the cache's 32-bit single-word SRAM requests (write-through writes, read-miss fills) into two 16-bit accesses on the external asynchronous SRAM.
- Returns a one-cycle ready pulse with the assembled 32-bit read word, so the cache can fill its line and release the ARM freeze.

Parameters:
- ADDR_W, 18, external SRAM half-word address width.
- WAIT_CYCLES, 2, clock cycles per 16-bit access; must be >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- write_en  input  1  write request from cache (SRAM_w_en).
- read_en  input  1  read request from cache (SRAM_r_en).
- address  input  32  byte address (SRAM_ADDR from cache).
- write_data  input  32  write word (SRAM_W_DQ from cache).
- read_data  output  32  assembled read word (SRAM_DQ to cache).
- ready  output  1  one-cycle completion pulse (sram_ready to cache).
- busy  output  1  high while an access is in progress.
- SRAM_DQ  inout  16  external data bus.
- SRAM_ADDR_O  output  ADDR_W  external half-word address.
- SRAM_WE_N  output  1  active-low write strobe.
- SRAM_OE_N  output  1  active-low output enable.
- SRAM_CE_N  output  1  active-low chip enable.
- SRAM_UB_N, SRAM_LB_N  output  1 each  byte enables; tied low whenever CE_N is low.

Behaviour:
- FSM states: IDLE, LO_ACC, HI_ACC, DONE. A wait counter spans 0..WAIT_CYCLES-1 within each ACC state.
- IDLE:
  - Requests are sampled only in IDLE.
  - If write_en or read_en is high, latch address, write_data and op into internal registers and go to LO_ACC with counter = 0.
  - If both are high, the write wins.
  - Requests in any other state are ignored.
- LO_ACC / HI_ACC:
  - SRAM_ADDR_O = {addr_q[ADDR_W:2], half}, with half = 0 in LO_ACC and 1 in HI_ACC. The low half-word sits at the even address.
  - The counter increments each cycle. On counter == WAIT_CYCLES-1, LO_ACC goes to HI_ACC, HI_ACC goes to DONE, and the counter clears.
- Read access:
  - CE_N = 0, OE_N = 0, WE_N = 1; SRAM_DQ is high-Z.
  - On the last cycle of LO_ACC, capture SRAM_DQ into rd_q[15:0]. On the last cycle of HI_ACC, capture it into rd_q[31:16].
- Write access:
  - CE_N = 0, OE_N = 1.
  - SRAM_DQ drives wd_q[15:0] in LO_ACC and wd_q[31:16] in HI_ACC.
  - WE_N = 0 on counter 0..WAIT_CYCLES-2 and 1 on the last cycle, so WE_N deasserts before the address changes.
- DONE:
  - ready = 1 for exactly one cycle, then go to IDLE.
  - read_data = rd_q, valid from DONE and held until the next read completes. Writes do not modify read_data.
- Latency: request sampled in IDLE at cycle 0, ready at cycle 2*WAIT_CYCLES+1 (cycle 5 at the default). Back-to-back accesses are separated by at least one IDLE cycle.
- Master rule: the cache must drop its request in the cycle after ready. A request still high in IDLE starts a new access.
- busy = 1 in LO_ACC, HI_ACC and DONE.
- Outside access states: CE_N = OE_N = WE_N = 1, SRAM_DQ is high-Z, SRAM_ADDR_O holds its last value.
- Reset (reset = 0) at any time, including mid-access:
  - State goes to IDLE immediately and the counter clears.
  - ready = 0, busy = 0, read_data = 0, SRAM_ADDR_O = 0.
  - All strobes go inactive high and the bus is released.
  - An aborted access produces no ready.
- Address bits above ADDR_W and bits [1:0] are ignored.

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE = 2'd0, LO_ACC = 2'd1, HI_ACC = 2'd2, DONE = 2'd3);
  - the default WAIT_CYCLES;
  - the default SRAM ADDR_W;
  - the 16-bit half-word width.
- No sub-module needed. An optional tri-state pad wrapper, sram_dq_buf, isolates the SRAM_DQ inout for synthesis.

Test Plan:
- Reset then idle:
  - Drive reset = 0 mid-cycle.
  - Required: ready = 0, busy = 0, read_data = 0, WE_N = OE_N = CE_N = 1, SRAM_DQ = Z.
- Read:
  - Model memory holds half 0x00100 = 0xBEEF and 0x00101 = 0xDEAD; assert read_en with address = 0x00000200.
  - Required: SRAM_ADDR_O = 0x00100 for 2 cycles, then 0x00101 for 2 cycles; ready at cycle 5; read_data = 0xDEADBEEF.
- Write:
  - Assert write_en with address = 0x00000404, write_data = 0x12345678.
  - Required: DQ = 0x5678 at address 0x00202 and DQ = 0x1234 at 0x00203; WE_N low only on counter 0 of each half; ready at cycle 5.
  - A follow-up read of 0x404 returns 0x12345678.
- Simultaneous request:
  - Assert read_en and write_en together.
  - Required: a write cycle occurs (WE_N toggles, OE_N = 1) and read_data is unchanged.
- Reset mid-access:
  - Drive reset low during HI_ACC of a read.
  - Required: no ready pulse, state IDLE, read_data = 0.
  - A fresh read afterwards completes normally in 5 cycles.
- Held request:
  - Keep read_en high after ready.
  - Required: a second access starts on the next IDLE cycle, with ready again 6 cycles after the first.
